// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 6-stage MiniMIPS32 pipeline: merges stall requests,
// redirects on exceptions/ERET, then holds fetch until the instruction bus drains.
module pipeline_ctrl #(
    parameter logic [31:0] EXC_VECTOR     = 32'hBFC00380,
    parameter int          DRAIN_MAX      = 8,
    parameter int          EXC_CODE_WIDTH = 5,
    parameter logic [EXC_CODE_WIDTH-1:0] EC_NONE    = 5'h10,
    parameter logic [EXC_CODE_WIDTH-1:0] EC_SYSCALL = 5'h08,
    parameter logic [EXC_CODE_WIDTH-1:0] EC_ERET    = 5'h11
) (
    input  logic                      cpu_clk_75M,
    input  logic                      cpu_rst_n,
    input  logic                      stallreq_if,
    input  logic                      stallreq_id,
    input  logic                      stallreq_ex,
    input  logic                      stallreq_mem,
    input  logic [EXC_CODE_WIDTH-1:0] exc_code_i,
    input  logic [31:0]               cp0_epc_i,
    input  logic                      ibus_busy_i,
    output logic [5:0]                stall,
    output logic                      flush,
    output logic [31:0]               new_pc,
    output logic                      in_drain_o
);

    localparam int CW = $clog2(DRAIN_MAX + 1);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t        state, state_next;
    logic [CW-1:0] drain_cnt, drain_cnt_next;

    always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
        end
    end

    // Outputs are forced low while reset is held, independent of the request inputs.
    always_comb begin
        stall          = 6'b000000;
        flush          = 1'b0;
        new_pc         = 32'h0;
        state_next     = state;
        drain_cnt_next = drain_cnt;
        if (cpu_rst_n) begin
            case (state)
                RUN: begin
                    if (exc_code_i != EC_NONE && !stallreq_mem) begin
                        flush          = 1'b1;
                        new_pc         = (exc_code_i == EC_ERET) ? cp0_epc_i : EXC_VECTOR;
                        state_next     = DRAIN;
                        drain_cnt_next = '0;
                    end else if (stallreq_mem) stall = 6'b011111;
                    else if (stallreq_ex)      stall = 6'b001111;
                    else if (stallreq_id)      stall = 6'b000111;
                    else if (stallreq_if)      stall = 6'b000011;
                end
                DRAIN: begin
                    stall = 6'b000011;
                    if (drain_cnt != CW'(DRAIN_MAX))
                        drain_cnt_next = drain_cnt + 1'b1;
                    // Watchdog: never wait on a stuck bus longer than DRAIN_MAX cycles.
                    if (!ibus_busy_i || drain_cnt == CW'(DRAIN_MAX - 1))
                        state_next = RUN;
                end
                default: state_next = RUN;
            endcase
        end
    end

    assign in_drain_o = cpu_rst_n && (state == DRAIN);

endmodule
